atm_keypad_scanner: RTL and testbench
=====================================

Name: atm_keypad_scanner

Overview:
- Producer end of the ATM keypad interface: scans a physical 4x4 active-low matrix keypad and debounces it.
- Emits one 4-bit key code per debounced press, plus a one-cycle strobe, for consumption by ATM_Machine's keypad input.
- Sits between board pins and the ATM controller in the same clock domain.
- Every code the controller acts on (digits 0-3, 4'b1101 mini statement) comes from this block.

Parameters:
- SCAN_HOLD, 4, cycles each column is driven before its rows are sampled; legal range is 3 or more (covers the 2-flop synchronizer).
- DEBOUNCE_CYCLES, 4, consecutive identical synchronized samples needed to accept a press or a release; legal range is 2 or more.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- row_in  in  4  keypad rows, active-low, pulled up externally; asynchronous to clk.
- col_out  out  4  column drive, active-low, exactly one bit low at all times.
- key_code  out  4  last accepted key = {row[1:0], col[1:0]}; holds its value until the next accept.
- key_valid  out  1  one-cycle pulse when key_code is updated.
- key_held  out  1  high from accept until the release is debounced.
- multi_key  out  1  one-cycle pulse when a scan sample shows more than one row low.

Behaviour:
- Reset (async assert, sync release) values:
  - col_out = 4'b1110, column index 0.
  - key_code = 0, key_valid = 0, key_held = 0, multi_key = 0.
  - State SCAN; all counters 0; synchronizer flops = 4'b1111.
- row_in passes through a 2-flop synchronizer to give rows_s. All decisions use rows_s only.
- SCAN:
  - Each edge: if hold_cnt == SCAN_HOLD-1, sample rows_s, set hold_cnt = 0 and advance the column (3 wraps to 0). Otherwise hold_cnt++.
  - Sample with rows_s all ones: keep scanning.
  - Sample with exactly one row low: latch that row and the current column, do not advance the column, go to DEBOUNCE with deb_cnt = 1.
  - Sample with two or more rows low: pulse multi_key, advance the column, keep scanning.
- DEBOUNCE:
  - Column is frozen.
  - Each edge, if rows_s equals the latched one-hot-low pattern, deb_cnt++.
  - On the edge where the count reaches DEBOUNCE_CYCLES: load key_code, pulse key_valid, set key_held = 1, go to PRESSED.
  - Any mismatch: return to SCAN at the next column, hold_cnt = 0, no outputs.
- Latency: key_valid rises DEBOUNCE_CYCLES-1 edges after the detecting sample edge.
- PRESSED:
  - Column stays frozen; key_held = 1.
  - Other keys are ignored, including keys in the same column and multi-row patterns.
  - rows_s all ones: go to RELEASE with rel_cnt = 1.
- RELEASE:
  - rows_s all ones: rel_cnt++. When it reaches DEBOUNCE_CYCLES, clear key_held and go to SCAN at the next column with hold_cnt = 0.
  - Any row low: return to PRESSED (bounce). No second key_valid is produced.
- Auto-repeat: none. A held key yields exactly one key_valid.
- key_valid and multi_key can never be high in the same cycle.
- Reset asserted mid-press: all state clears immediately. If the key is still held after reset release, it is re-detected and re-accepted as a new press.
- Column advance with no keys pressed: one column per SCAN_HOLD cycles; a full sweep takes 4*SCAN_HOLD cycles.

Test Plan:
- Bench keypad model: row_in[r] = 0 iff key(r,c) is pressed and col_out[c] == 0.
- Reset with no keys pressed: col_out = 4'b1110; after each SCAN_HOLD = 4 cycles it steps 1101, 1011, 0111, then 1110 again. key_valid, key_held and multi_key stay 0.
- Key (row2,col1) held from reset release: column 1 is sampled at edge 8 and key_valid pulses after edge 11 with key_code = 4'b1001. key_held = 1. Holding 100 cycles gives no further pulse.
- Press digits 0, 1, 2, 3 (row0, cols 0-3) sequentially, each held 20 cycles with 20-cycle gaps: exactly four key_valid pulses with codes 0000, 0001, 0010, 0011. key_held drops 4 cycles after each release.
- Key (row3,col1) with 2-cycle bounces during press and release: exactly one key_valid with code 4'b1101. The release bounce keeps key_held = 1 until 4 clean cycles.
- Keys (row0,col2) and (row1,col2) pressed together: multi_key pulses once per sweep of column 2, and key_valid never fires.
- Reset pulled low while in PRESSED: all outputs clear within the same cycle. After release with the key still held, one new key_valid is produced with the same code.

Source files
------------

// File: rtl/atm_keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with debounce. Emits one key code and a
// one-cycle key_valid per debounced press. key_held covers press to debounced release.
module atm_keypad_scanner #(
    parameter int SCAN_HOLD       = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_key
);

    localparam int HW = (SCAN_HOLD > 1) ? $clog2(SCAN_HOLD) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(SCAN_HOLD - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t          state;
    logic [3:0]      sync1, rows_s;
    logic [1:0]      col_idx;
    logic [HW-1:0]   hold_cnt;
    logic [DW-1:0]   deb_cnt;   // press count in DEBOUNCE, release count in RELEASE
    logic [3:0]      row_pat;
    logic [1:0]      row_idx;
    logic            one_low;
    logic [1:0]      low_idx;
    logic            all_high;
    logic [1:0]      col_next;

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        col_drive = ~(4'b0001 << c);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 4'b1111;
            rows_s <= 4'b1111;
        end else begin
            sync1  <= row_in;
            rows_s <= sync1;
        end
    end

    always_comb begin
        one_low = 1'b1;
        low_idx = 2'd0;
        case (rows_s)
            4'b1110: low_idx = 2'd0;
            4'b1101: low_idx = 2'd1;
            4'b1011: low_idx = 2'd2;
            4'b0111: low_idx = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    assign all_high = &rows_s;
    assign col_next = col_idx + 2'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            col_out   <= 4'b1110;
            hold_cnt  <= '0;
            deb_cnt   <= '0;
            row_pat   <= 4'b1111;
            row_idx   <= 2'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            multi_key <= 1'b0;
            case (state)
                SCAN: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (one_low) begin
                            // column stays put so the debounce watches the same key
                            row_pat <= rows_s;
                            row_idx <= low_idx;
                            deb_cnt <= DW'(1);
                            state   <= DEBOUNCE;
                        end else begin
                            col_idx <= col_next;
                            col_out <= col_drive(col_next);
                            if (!all_high) multi_key <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (rows_s == row_pat) begin
                        if (deb_cnt == DEB_LAST) begin
                            key_code  <= {row_idx, col_idx};
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            state     <= PRESSED;
                        end else begin
                            deb_cnt <= deb_cnt + DW'(1);
                        end
                    end else begin
                        col_idx  <= col_next;
                        col_out  <= col_drive(col_next);
                        hold_cnt <= '0;
                        state    <= SCAN;
                    end
                end
                PRESSED: begin
                    if (all_high) begin
                        deb_cnt <= DW'(1);
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!all_high) begin
                        state <= PRESSED;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_held <= 1'b0;
                        col_idx  <= col_next;
                        col_out  <= col_drive(col_next);
                        hold_cnt <= '0;
                        state    <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_keypad_scanner.sv
// Directed bench for atm_keypad_scanner: keypad matrix model, vector table, corner sequences.
module tb_atm_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multi_key;

    logic [15:0] keys;          // bit r*4+c = key(row r, col c) pressed
    int total = 0;
    int bad   = 0;
    int vcnt  = 0;
    int mcnt  = 0;
    logic both_seen = 1'b0;

    atm_keypad_scanner #(.SCAN_HOLD(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .row_in(row_in), .col_out(col_out),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
        .multi_key(multi_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
    end

    always @(posedge clk) begin
        #1;
        if (key_valid) vcnt++;
        if (multi_key) mcnt++;
        if (key_valid && multi_key) both_seen = 1'b1;
    end

    typedef struct {
        logic [15:0] keys;
        int          cycles;
        int          exp_v;     // -1 = don't care
        int          exp_m;
        int          exp_held;
        logic [3:0]  exp_code;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic hold(input logic [15:0] k, input int n);
        keys = k;
        repeat (n) @(negedge clk);
    endtask

    int v0, m0;

    initial begin
        reset = 1'b1;
        keys  = 16'h0;
        #2 reset = 1'b0;

        // reset state and idle column walk
        repeat (2) @(negedge clk);
        chk("rst_col", col_out, 4'b1110);
        chk("rst_valid", key_valid, 0);
        chk("rst_held", key_held, 0);
        chk("rst_multi", multi_key, 0);
        chk("rst_code", key_code, 0);
        reset = 1'b1;
        v0 = vcnt; m0 = mcnt;
        repeat (4) @(negedge clk); chk("walk1", col_out, 4'b1101);
        repeat (4) @(negedge clk); chk("walk2", col_out, 4'b1011);
        repeat (4) @(negedge clk); chk("walk3", col_out, 4'b0111);
        repeat (4) @(negedge clk); chk("walk0", col_out, 4'b1110);
        chk("walk_nov", vcnt - v0, 0);
        chk("walk_nom", mcnt - m0, 0);
        chk("walk_held", key_held, 0);

        // key (2,1) held from reset release: sampled edge 8, accepted edge 11
        keys = 16'h0200;
        do_reset(2);
        v0 = vcnt;
        repeat (10) @(negedge clk);
        chk("r2c1_pre", key_valid, 0);
        @(negedge clk);
        chk("r2c1_valid", key_valid, 1);
        chk("r2c1_code", key_code, 4'b1001);
        chk("r2c1_held", key_held, 1);
        @(negedge clk);
        chk("r2c1_pulse", key_valid, 0);
        chk("r2c1_frozen", col_out, 4'b1101);
        repeat (100) @(negedge clk);
        chk("r2c1_norep", vcnt - v0, 1);
        chk("r2c1_held100", key_held, 1);
        hold(16'h0, 10);
        chk("r2c1_rel", key_held, 0);

        // vector table: digits 0..3 then a two-row press in column 2
        tbl[0]  = '{16'h0001, 20, 1, 0, 1, 4'b0000};
        tbl[1]  = '{16'h0000, 20, 0, 0, 0, 4'b0000};
        tbl[2]  = '{16'h0002, 20, 1, 0, 1, 4'b0001};
        tbl[3]  = '{16'h0000, 20, 0, 0, 0, 4'b0000};
        tbl[4]  = '{16'h0004, 20, 1, 0, 1, 4'b0010};
        tbl[5]  = '{16'h0000, 20, 0, 0, 0, 4'b0000};
        tbl[6]  = '{16'h0008, 20, 1, 0, 1, 4'b0011};
        tbl[7]  = '{16'h0000, 20, 0, 0, 0, 4'b0000};
        tbl[8]  = '{16'h0044, 16, 0, -1, 0, 4'b0000};
        tbl[9]  = '{16'h0044, 64, 0, 4, 0, 4'b0000};
        tbl[10] = '{16'h0000, 8, 0, -1, 0, 4'b0000};
        do_reset(2);
        for (int i = 0; i < 11; i++) begin
            v0 = vcnt; m0 = mcnt;
            hold(tbl[i].keys, tbl[i].cycles);
            if (tbl[i].exp_v >= 0) chk($sformatf("vec%0d_valid", i), vcnt - v0, tbl[i].exp_v);
            if (tbl[i].exp_m >= 0) chk($sformatf("vec%0d_multi", i), mcnt - m0, tbl[i].exp_m);
            if (tbl[i].exp_held >= 0) chk($sformatf("vec%0d_held", i), key_held, tbl[i].exp_held);
            if (tbl[i].exp_v == 1) chk($sformatf("vec%0d_code", i), key_code, tbl[i].exp_code);
        end

        // key (3,1) with bounce on press and release
        do_reset(2);
        v0 = vcnt;
        hold(16'h2000, 3);
        hold(16'h0000, 2);
        hold(16'h2000, 2);
        hold(16'h0000, 2);
        hold(16'h2000, 40);
        chk("bnc_valid", vcnt - v0, 1);
        chk("bnc_code", key_code, 4'b1101);
        chk("bnc_held", key_held, 1);
        hold(16'h0000, 2);
        chk("bnc_rel1", key_held, 1);
        hold(16'h2000, 2);
        hold(16'h0000, 2);
        hold(16'h2000, 1);
        chk("bnc_rel2", key_held, 1);
        hold(16'h0000, 5);
        chk("bnc_rel3", key_held, 1);
        @(negedge clk);
        chk("bnc_drop", key_held, 0);
        hold(16'h0000, 10);
        chk("bnc_once", vcnt - v0, 1);

        // reset asserted while PRESSED, key still held afterwards
        do_reset(2);
        v0 = vcnt;
        hold(16'h0080, 30);
        chk("mid_valid", vcnt - v0, 1);
        chk("mid_code", key_code, 4'b0111);
        chk("mid_held", key_held, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_held", key_held, 0);
        chk("mid_rst_code", key_code, 0);
        chk("mid_rst_col", col_out, 4'b1110);
        chk("mid_rst_valid", key_valid, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        v0 = vcnt;
        repeat (30) @(negedge clk);
        chk("mid_revalid", vcnt - v0, 1);
        chk("mid_recode", key_code, 4'b0111);
        chk("mid_reheld", key_held, 1);
        hold(16'h0000, 10);

        chk("valid_multi_excl", int'(both_seen), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
